// File: rtl/fixed_point_requantizer.sv
// Two-stage valid/ready requantizer: signed Q(DATA_IN) -> Q(DATA_OUT) with selectable rounding and saturation.
// Optional saturation event counter enabled by defining REQUANT_SAT_COUNT_EN.
module fixed_point_requantizer #(
  parameter int DATA_IN_WIDTH  = 8,
  parameter int FRAC_IN_WIDTH  = 6,
  parameter int DATA_OUT_WIDTH = 4,
  parameter int FRAC_OUT_WIDTH = 2,
  parameter int SAT_CNT_WIDTH  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_IN_WIDTH-1:0]  i_data_in,
  input  logic [1:0]                i_mode,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [DATA_OUT_WIDTH-1:0] o_data_out,
  output logic                      o_sat,
  output logic                      o_valid,
`ifdef REQUANT_SAT_COUNT_EN
  input  logic                      i_sat_clr,
  output logic [SAT_CNT_WIDTH-1:0]  o_sat_count,
`endif
  input  logic                      i_ready
);

  localparam int SH = FRAC_IN_WIDTH - FRAC_OUT_WIDTH;
  localparam int KW = DATA_IN_WIDTH - SH;
  localparam int VW = KW + 1;
  localparam int WW = ((VW > DATA_OUT_WIDTH) ? VW : DATA_OUT_WIDTH) + 1;

  localparam logic [1:0] MODE_HALF_UP   = 2'b01;
  localparam logic [1:0] MODE_HALF_EVEN = 2'b10;
  localparam logic [1:0] MODE_SIGN      = 2'b11;

  localparam logic signed [VW-1:0] POS_ONE = VW'(1 << FRAC_OUT_WIDTH);
  localparam logic signed [VW-1:0] NEG_ONE = -POS_ONE;
  localparam logic signed [WW-1:0] SAT_MAX = WW'((1 << (DATA_OUT_WIDTH - 1)) - 1);
  localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;

  // Parameter sanity: an out-of-range configuration elaborates this empty marker block.
  if (FRAC_IN_WIDTH < FRAC_OUT_WIDTH || DATA_OUT_WIDTH - FRAC_OUT_WIDTH < 2 || SAT_CNT_WIDTH < 1)
  begin : g_illegal_params
  end

  // ---------------- Stage 1: rounding ----------------
  logic signed [KW-1:0] k;
  logic                 round_up;
  logic signed [VW-1:0] s1_v_d;
  logic signed [VW-1:0] s1_v_q;
  logic                 s1_valid_q;

  // Taking the upper bits is the arithmetic shift right by SH.
  assign k = $signed(i_data_in[DATA_IN_WIDTH-1:SH]);

  if (SH == 0) begin : g_no_round
    assign round_up = 1'b0;
  end else begin : g_round
    localparam logic [SH-1:0] HALF = SH'(1) << (SH - 1);
    logic [SH-1:0] r;
    assign r = i_data_in[SH-1:0];
    always_comb begin
      round_up = 1'b0;
      case (i_mode)
        MODE_HALF_UP:   round_up = (r >= HALF);
        MODE_HALF_EVEN: round_up = (r > HALF) | ((r == HALF) & k[0]);
        default:        round_up = 1'b0;
      endcase
    end
  end

  always_comb begin
    s1_v_d = {k[KW-1], k} + VW'(round_up);
    if (i_mode == MODE_SIGN) begin
      s1_v_d = i_data_in[DATA_IN_WIDTH-1] ? NEG_ONE : POS_ONE;
    end
  end

  // ---------------- Stage 2: saturation ----------------
  logic signed [WW-1:0]      v_ext;
  logic [DATA_OUT_WIDTH-1:0] s2_data_d;
  logic                      s2_sat_d;
  logic [DATA_OUT_WIDTH-1:0] s2_data_q;
  logic                      s2_sat_q;
  logic                      s2_valid_q;
  logic                      s2_load;
  logic                      s1_load;

  assign v_ext = {{(WW - VW){s1_v_q[VW-1]}}, s1_v_q};

  // SIGN values are +/-1.0, always in range, so they never flag saturation.
  always_comb begin
    s2_data_d = v_ext[DATA_OUT_WIDTH-1:0];
    s2_sat_d  = 1'b0;
    if (v_ext > SAT_MAX) begin
      s2_data_d = SAT_MAX[DATA_OUT_WIDTH-1:0];
      s2_sat_d  = 1'b1;
    end else if (v_ext < SAT_MIN) begin
      s2_data_d = SAT_MIN[DATA_OUT_WIDTH-1:0];
      s2_sat_d  = 1'b1;
    end
  end

  // Ready looks through the output register so a full pipe still streams 1 sample/cycle.
  assign s2_load = !s2_valid_q | i_ready;
  assign s1_load = !s1_valid_q | s2_load;
  assign o_ready = s1_load;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_v_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= i_valid;
        if (i_valid) begin
          s1_v_q <= s1_v_d;
        end
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s2_data_d;
          s2_sat_q  <= s2_sat_d;
        end
      end
    end
  end

  assign o_valid    = s2_valid_q;
  assign o_data_out = s2_data_q;
  assign o_sat      = s2_sat_q;

`ifdef REQUANT_SAT_COUNT_EN
  logic [SAT_CNT_WIDTH-1:0] sat_count_q;
  logic [SAT_CNT_WIDTH-1:0] sat_count_d;

  always_comb begin
    sat_count_d = sat_count_q;
    if (i_sat_clr) begin
      sat_count_d = '0;
    end else if (s2_valid_q & i_ready & s2_sat_q & ~(&sat_count_q)) begin
      sat_count_d = sat_count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sat_count_q <= '0;
    end else begin
      sat_count_q <= sat_count_d;
    end
  end

  assign o_sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_fixed_point_requantizer.sv
// Directed-vector bench for fixed_point_requantizer at the default Q2.6 -> Q2.2 format.
// Counter checks are active when REQUANT_SAT_COUNT_EN is defined.
module tb_fixed_point_requantizer;

  localparam logic [1:0] TRUNC = 2'b00;
  localparam logic [1:0] HUP   = 2'b01;
  localparam logic [1:0] HEVEN = 2'b10;
  localparam logic [1:0] SIGN  = 2'b11;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_data_in;
  logic [1:0] i_mode;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] o_data_out;
  logic       o_sat;
  logic       o_valid;
  logic       i_ready;

  int checks = 0;
  int errors = 0;

`ifdef REQUANT_SAT_COUNT_EN
  logic        i_sat_clr;
  logic [15:0] o_sat_count;
  logic [1:0]  small_sat_count;
  logic        small_ready;
  logic [3:0]  small_data;
  logic        small_sat;
  logic        small_valid;
`endif

  fixed_point_requantizer dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data_in  (i_data_in),
    .i_mode     (i_mode),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data_out (o_data_out),
    .o_sat      (o_sat),
    .o_valid    (o_valid),
`ifdef REQUANT_SAT_COUNT_EN
    .i_sat_clr  (i_sat_clr),
    .o_sat_count(o_sat_count),
`endif
    .i_ready    (i_ready)
  );

`ifdef REQUANT_SAT_COUNT_EN
  fixed_point_requantizer #(.SAT_CNT_WIDTH(2)) dut_small (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data_in  (i_data_in),
    .i_mode     (i_mode),
    .i_valid    (i_valid),
    .o_ready    (small_ready),
    .o_data_out (small_data),
    .o_sat      (small_sat),
    .o_valid    (small_valid),
    .i_sat_clr  (i_sat_clr),
    .o_sat_count(small_sat_count),
    .i_ready    (i_ready)
  );
`endif

  always #5 i_clk = ~i_clk;

  // Sends one sample and captures its result at the negedge where o_valid first rises.
  task automatic run_one(input logic [7:0] d, input logic [1:0] m,
                         output logic [3:0] q, output logic s, output int lat);
    int n;
    logic found;
    @(posedge i_clk); #1;
    i_data_in = d; i_mode = m; i_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    q = 'x; s = 1'bx;
    lat = 0; found = 1'b0;
    while (!found && lat < 10) begin
      @(negedge i_clk);
      lat++;
      if (o_valid) begin
        found = 1'b1; q = o_data_out; s = o_sat;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL timeout: no o_valid for input %h mode %0d", d, m);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_data_in = 8'h00; i_mode = TRUNC;
`ifdef REQUANT_SAT_COUNT_EN
    i_sat_clr = 1'b0;
`endif
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_data_out !== 4'h0) begin errors++; $display("FAIL reset_data: got %h want 0", o_data_out); end
    checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", o_sat); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
`ifdef REQUANT_SAT_COUNT_EN
    checks++; if (o_sat_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_sat_count); end
`endif
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_rounding();
    logic [7:0] din  [9] = '{8'h18, 8'h18, 8'h18, 8'h28, 8'h28, 8'h28, 8'h7F, 8'h80, 8'h11};
    logic [1:0] mode [9] = '{HUP, HEVEN, TRUNC, HUP, HEVEN, TRUNC, HUP, TRUNC, HEVEN};
    logic [3:0] expq [9] = '{4'h2, 4'h2, 4'h1, 4'h3, 4'h2, 4'h2, 4'h7, 4'h8, 4'h1};
    logic       exps [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] q;
    logic s;
    int lat;
    for (int i = 0; i < 9; i++) begin
      run_one(din[i], mode[i], q, s, lat);
      $display("round in=%h mode=%0d -> out=%h sat=%b lat=%0d", din[i], mode[i], q, s, lat);
      checks++; if (q !== expq[i]) begin errors++; $display("FAIL round_data[%0d]: got %h want %h", i, q, expq[i]); end
      checks++; if (s !== exps[i]) begin errors++; $display("FAIL round_sat[%0d]: got %b want %b", i, s, exps[i]); end
      if (i == 0) begin
        checks++; if (lat != 2) begin errors++; $display("FAIL latency: got %0d want 2", lat); end
      end
    end
  endtask

  task automatic test_sign();
    logic [7:0] din  [3] = '{8'h80, 8'h00, 8'h7F};
    logic [3:0] expq [3] = '{4'hC, 4'h4, 4'h4};
    logic [3:0] q;
    logic s;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_one(din[i], SIGN, q, s, lat);
      $display("sign in=%h -> out=%h sat=%b", din[i], q, s);
      checks++; if (q !== expq[i]) begin errors++; $display("FAIL sign_data[%0d]: got %h want %h", i, q, expq[i]); end
      checks++; if (s !== 1'b0) begin errors++; $display("FAIL sign_sat[%0d]: got %b want 0", i, s); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] din  [4] = '{8'h18, 8'h28, 8'h80, 8'h00};
    logic [1:0] mode [4] = '{TRUNC, HEVEN, TRUNC, SIGN};
    logic [3:0] expq [4] = '{4'h1, 4'h2, 4'h8, 4'h4};
    i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    for (int t = 0; t < 6; t++) begin
      @(posedge i_clk); #1;
      if (t < 4) begin
        i_valid = 1'b1; i_data_in = din[t]; i_mode = mode[t];
      end else begin
        i_valid = 1'b0;
      end
      @(negedge i_clk);
      if (t < 4) begin
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", t, o_ready); end
      end
      if (t >= 2) begin
        $display("stream cycle %0d out=%h valid=%b", t, o_data_out, o_valid);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", t, o_valid); end
        checks++; if (o_data_out !== expq[t-2]) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", t, o_data_out, expq[t-2]); end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] din  [3] = '{8'h18, 8'h28, 8'h7F};
    logic [3:0] expq [3] = '{4'h2, 4'h3, 4'h7};
    logic       exps [3] = '{1'b0, 1'b0, 1'b1};
    repeat (2) @(posedge i_clk);
    #1;
    i_ready = 1'b0; i_mode = HUP;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1; i_data_in = din[i];
      @(negedge i_clk);
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stall_accept[%0d]: got %b want 1", i, o_ready); end
      @(posedge i_clk); #1;
    end
    i_data_in = din[2];
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      $display("stall cycle %0d ready=%b valid=%b out=%h", c, o_ready, o_valid, o_data_out);
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", c, o_ready); end
      checks++; if (o_valid !== 1'b1 || o_data_out !== 4'h2) begin
        errors++; $display("FAIL stall_hold[%0d]: got valid=%b data=%h want valid=1 data=2", c, o_valid, o_data_out);
      end
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", o_ready); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge i_clk);
      $display("drain %0d valid=%b out=%h sat=%b", i, o_valid, o_data_out, o_sat);
      checks++; if (o_valid !== 1'b1 || o_data_out !== expq[i] || o_sat !== exps[i]) begin
        errors++; $display("FAIL drain[%0d]: got valid=%b data=%h sat=%b want valid=1 data=%h sat=%b",
                           i, o_valid, o_data_out, o_sat, expq[i], exps[i]);
      end
      @(posedge i_clk); #1;
      i_valid = 1'b0;
    end
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", o_valid); end
  endtask

  task automatic test_reset_in_flight();
    @(posedge i_clk); #1;
    i_ready = 1'b0; i_mode = HUP;
    i_valid = 1'b1; i_data_in = 8'h18;
    @(posedge i_clk); #1;
    i_data_in = 8'h28;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    $display("flush valid=%b out=%h ready=%b", o_valid, o_data_out, o_ready);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", o_valid); end
    checks++; if (o_data_out !== 4'h0) begin errors++; $display("FAIL flush_data: got %h want 0", o_data_out); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", o_ready); end
    i_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_stale[%0d]: got valid %b want 0", c, o_valid); end
    end
  endtask

`ifdef REQUANT_SAT_COUNT_EN
  task automatic test_sat_count();
    logic [3:0] q;
    logic s;
    int lat;
    @(posedge i_clk); #1;
    i_ready = 1'b1; i_sat_clr = 1'b1;
    @(posedge i_clk); #1;
    i_sat_clr = 1'b0;
    checks++; if (o_sat_count !== 16'd0) begin errors++; $display("FAIL count_clear: got %0d want 0", o_sat_count); end
    for (int i = 0; i < 5; i++) run_one(8'h7F, HUP, q, s, lat);
    @(posedge i_clk); #1;
    $display("count after 5 sat: wide=%0d small=%0d", o_sat_count, small_sat_count);
    checks++; if (o_sat_count !== 16'd5) begin errors++; $display("FAIL count_five: got %0d want 5", o_sat_count); end
    run_one(8'h7F, HUP, q, s, lat);
    @(posedge i_clk); #1;
    checks++; if (o_sat_count !== 16'd6) begin errors++; $display("FAIL count_six: got %0d want 6", o_sat_count); end
    checks++; if (small_sat_count !== 2'd3) begin errors++; $display("FAIL count_sticky: got %0d want 3", small_sat_count); end
    run_one(8'h7F, HUP, q, s, lat);
    i_sat_clr = 1'b1;
    @(posedge i_clk); #1;
    i_sat_clr = 1'b0;
    $display("count after clr+handshake: wide=%0d valid=%b", o_sat_count, o_valid);
    checks++; if (o_sat_count !== 16'd0) begin errors++; $display("FAIL count_clr_prio: got %0d want 0", o_sat_count); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL count_handshake: got valid %b want 0", o_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_rounding();
    test_sign();
    test_back_to_back();
    test_stall();
    test_reset_in_flight();
`ifdef REQUANT_SAT_COUNT_EN
    test_sat_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
